vec_alu_sched: RTL and testbench

Sequencer and two-port arbiter for the shared 16-lane vector ALU (`ALU_vec`).
- Accepts operation requests from two requesters, for example the vector issue stage and the scalar-broadcast path.
- Grants them round-robin and registers operands and opcode onto the ALU inputs.
- Budgets a multi-cycle path for multiply and returns the captured result and flags, tagged with the requester ID, over a valid/ready response port.
- Sits between the decode/issue logic and the single `ALU_vec` instance in the execute stage.

---
 rtl/vec_alu_sched.sv | 94 +++++++++
 tb/tb_vec_alu_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vec_alu_sched.sv
// vec_alu_sched: round-robin two-requester sequencer for the shared vector ALU
// Registers one operation onto the ALU, waits out its latency, then returns the captured result.
module vec_alu_sched #(
    parameter int WIDTH_V = 128,
    parameter int bits_index = 8,
    parameter int MUL_LAT = 2,
    localparam int NL = WIDTH_V / bits_index
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*WIDTH_V-1:0]    req_a,
    input  logic [2*WIDTH_V-1:0]    req_b,
    input  logic [2*bits_index-1:0] req_c,
    input  logic [5:0]              req_op,
    output logic [WIDTH_V-1:0]      alu_a,
    output logic [WIDTH_V-1:0]      alu_b,
    output logic [bits_index-1:0]   alu_c,
    output logic [2:0]              alu_op,
    input  logic [WIDTH_V-1:0]      alu_result,
    input  logic [NL*4-1:0]         alu_flags,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [WIDTH_V-1:0]      rsp_result,
    output logic [NL*4-1:0]         rsp_flags,
    output logic                    rsp_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = MUL_LAT > 1 ? $clog2(MUL_LAT) : 1;

    logic [1:0]    state;
    logic          ptr;
    logic          ill;
    logic [CW-1:0] cnt;
    logic          gnt;
    logic          hs;
    logic          legal;
    logic [2:0]    op_g;

    always_comb begin
        gnt = req_valid[ptr] ? ptr : ~ptr;
        req_ready = (state == IDLE && !rst) ? (req_valid & (gnt ? 2'b10 : 2'b01)) : 2'b00;
        hs = |req_ready;
        op_g = gnt ? req_op[5:3] : req_op[2:0];
        legal = op_g == 3'b000 || op_g == 3'b001 || op_g == 3'b010 || op_g == 3'b111;
    end

    assign rsp_valid = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            ill        <= 1'b0;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_c      <= '0;
            alu_op     <= 3'b010;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else if (state == IDLE) begin
            if (hs) begin
                alu_a  <= gnt ? req_a[2*WIDTH_V-1:WIDTH_V] : req_a[WIDTH_V-1:0];
                alu_b  <= gnt ? req_b[2*WIDTH_V-1:WIDTH_V] : req_b[WIDTH_V-1:0];
                alu_c  <= gnt ? req_c[2*bits_index-1:bits_index] : req_c[bits_index-1:0];
                // illegal opcodes run as a harmless add and are discarded at capture
                alu_op <= legal ? op_g : 3'b010;
                ill    <= ~legal;
                cnt    <= (legal && op_g == 3'b000) ? CW'(MUL_LAT - 1) : '0;
                rsp_id <= gnt;
                ptr    <= ~gnt;
                state  <= EXEC;
            end
        end else if (state == EXEC) begin
            if (cnt == '0) begin
                rsp_result <= ill ? '0 : alu_result;
                rsp_flags  <= ill ? '0 : alu_flags;
                rsp_err    <= ill;
                state      <= DONE;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else if (rsp_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_vec_alu_sched.sv
// tb_vec_alu_sched: directed and random checks of vec_alu_sched against a lane-level ALU model
module tb_vec_alu_sched;
    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [255:0] req_a;
    logic [255:0] req_b;
    logic [15:0]  req_c;
    logic [5:0]   req_op;
    logic [127:0] alu_a;
    logic [127:0] alu_b;
    logic [7:0]   alu_c;
    logic [2:0]   alu_op;
    logic [127:0] alu_result;
    logic [63:0]  alu_flags;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [127:0] rsp_result;
    logic [63:0]  rsp_flags;
    logic         rsp_err;

    int  n_chk;
    int  n_fail;
    logic ptr_m;

    vec_alu_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_op(alu_op),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] alu_fn(input logic [2:0] op, input logic [127:0] a, input logic [127:0] b, input logic [7:0] c);
        logic [127:0] r;
        r = '0;
        for (int l = 0; l < 16; l++) begin
            logic [7:0] x;
            logic [7:0] y;
            x = a[l*8 +: 8];
            y = b[l*8 +: 8];
            r[l*8 +: 8] = op == 3'b000 ? 8'(x * y) : op == 3'b001 ? 8'(x - y) :
                          op == 3'b010 ? 8'(x + y) : op == 3'b111 ? c : 8'h00;
        end
        return r;
    endfunction

    function automatic logic [63:0] flag_fn(input logic [2:0] op, input logic [127:0] a, input logic [127:0] b, input logic [7:0] c);
        logic [127:0] r;
        logic [63:0]  f;
        r = alu_fn(op, a, b, c);
        for (int l = 0; l < 16; l++)
            f[l*4 +: 4] = {r[l*8 +: 8] == 8'h00, r[l*8+7], a[l*8 +: 8] < b[l*8 +: 8], a[l*8 +: 8] == b[l*8 +: 8]};
        return f;
    endfunction

    // stand-in for the execute-stage ALU
    always_comb begin
        alu_result = alu_fn(alu_op, alu_a, alu_b, alu_c);
        alu_flags  = flag_fn(alu_op, alu_a, alu_b, alu_c);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_alu_a", alu_a, 128'(0));
        chk("rst_alu_b", alu_b, 128'(0));
        chk("rst_alu_c", 128'(alu_c), 128'(0));
        chk("rst_alu_op", 128'(alu_op), 128'(3'b010));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_id", 128'(rsp_id), 128'(0));
        chk("rst_rsp_result", rsp_result, 128'(0));
        chk("rst_rsp_flags", 128'(rsp_flags), 128'(0));
        chk("rst_rsp_err", 128'(rsp_err), 128'(0));
    endtask

    task automatic txn(input logic [1:0] v, input logic [2:0] o0, input logic [2:0] o1,
                       input logic [127:0] a0, input logic [127:0] a1, input logic [127:0] b0, input logic [127:0] b1,
                       input logic [7:0] c0, input logic [7:0] c1, input int stall, input bit wiggle);
        logic id;
        logic il;
        logic [2:0] op;
        logic [127:0] a;
        logic [127:0] b;
        logic [7:0] c;
        logic [127:0] er;
        logic [63:0] ef;
        int lat;
        id = v == 2'b11 ? ptr_m : v == 2'b10;
        ptr_m = !id;
        op = id ? o1 : o0;
        a = id ? a1 : a0;
        b = id ? b1 : b0;
        c = id ? c1 : c0;
        il = !(op inside {3'd0, 3'd1, 3'd2, 3'd7});
        lat = (op == 3'd0) ? 2 : 1;
        er = il ? 128'(0) : alu_fn(op, a, b, c);
        ef = il ? 64'(0) : flag_fn(op, a, b, c);
        req_valid = v;
        req_op = {o1, o0};
        req_a = {a1, a0};
        req_b = {b1, b0};
        req_c = {c1, c0};
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("req_ready_grant", 128'(req_ready), 128'(id ? 2'b10 : 2'b01));
        @(posedge clk); #1;
        rsp_ready = stall == 0;
        if (wiggle) req_valid = 2'($urandom);
        for (int j = 1; j <= lat; j++) begin
            @(negedge clk);
            chk("alu_op", 128'(alu_op), 128'(il ? 3'b010 : op));
            chk("busy_rsp_valid", 128'(rsp_valid), 128'(0));
            chk("busy_req_ready", 128'(req_ready), 128'(0));
            if (j == 1) begin
                chk("alu_a", alu_a, a);
                chk("alu_b", alu_b, b);
                chk("alu_c", 128'(alu_c), 128'(c));
            end
            @(posedge clk); #1;
            if (wiggle) req_valid = 2'($urandom);
        end
        @(negedge clk);
        chk("rsp_valid", 128'(rsp_valid), 128'(1));
        chk("rsp_id", 128'(rsp_id), 128'(id));
        chk("rsp_result", rsp_result, er);
        chk("rsp_flags", 128'(rsp_flags), 128'(ef));
        chk("rsp_err", 128'(rsp_err), 128'(il));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            if (s == stall - 1) rsp_ready = 1'b1;
            @(negedge clk);
            chk("stall_rsp_valid", 128'(rsp_valid), 128'(1));
            chk("stall_rsp_result", rsp_result, er);
            chk("stall_rsp_id", 128'(rsp_id), 128'(id));
            chk("stall_req_ready", 128'(req_ready), 128'(0));
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [127:0] rep(input logic [7:0] x);
        return {16{x}};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        ptr_m = 1'b0;
        rst = 1'b1;
        req_valid = 2'b11;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        chk("idle_no_rsp", 128'(rsp_valid), 128'(0));
        @(posedge clk); #1;

        txn(2'b01, 3'b010, 3'b000, rep(8'h0A), '0, rep(8'h14), '0, 8'h00, 8'h00, 0, 0);
        txn(2'b10, 3'b000, 3'b000, '0, rep(8'h05), '0, rep(8'h06), 8'h00, 8'h00, 0, 0);
        for (int k = 0; k < 4; k++)
            txn(2'b11, 3'b001, 3'b111, rep(8'h32), rnd128(), rep(8'h14), rnd128(), 8'h00, 8'h2A, 0, 0);
        txn(2'b01, 3'b101, 3'b000, rnd128(), '0, rnd128(), '0, 8'h11, 8'h00, 0, 0);
        txn(2'b01, 3'b010, 3'b000, rnd128(), '0, rnd128(), '0, 8'h00, 8'h00, 0, 0);
        txn(2'b01, 3'b001, 3'b000, rnd128(), '0, rnd128(), '0, 8'h00, 8'h00, 5, 0);

        req_valid = 2'b01;
        req_op = 6'b000_000;
        req_a = {128'(0), rep(8'h03)};
        req_b = {128'(0), rep(8'h07)};
        @(negedge clk);
        chk("mul_grant", 128'(req_ready), 128'(2'b01));
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("mul_exec", 128'(rsp_valid), 128'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ptr_m = 1'b0;
        @(negedge clk);
        chk_reset();
        chk("post_rst_req_ready", 128'(req_ready), 128'(0));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("dropped_rsp", 128'(rsp_valid), 128'(0));
        end
        @(posedge clk); #1;
        txn(2'b11, 3'b010, 3'b001, rnd128(), rnd128(), rnd128(), rnd128(), 8'h00, 8'h00, 0, 0);

        for (int k = 0; k < 30; k++)
            txn(2'($urandom_range(1, 3)), 3'($urandom), 3'($urandom), rnd128(), rnd128(), rnd128(), rnd128(),
                8'($urandom), 8'($urandom), $urandom_range(0, 2), 1);
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
